csr_access_unit: RTL and testbench

//  Initiator side of the CSR register file port. Accepts one Zicsr instruction at a time from execute
//  (CSRRW/S/C and immediate forms), reads the old CSR value, computes the new value and issues the

---
 rtl/csr_access_unit_pkg.sv | 32 +++
 rtl/csr_access_unit_if.sv | 30 +++
 rtl/csr_access_unit_csr_alu.sv | 41 ++++
 rtl/csr_access_unit.sv | 104 ++++++++++
 tb/tb_csr_access_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared constants for the CSR access unit: Zicsr funct3 codes, the
// read-only address field and the 2-bit FSM state encodings.
package csr_access_unit_pkg;

  localparam logic [2:0] CSR_FUNCT3_RW  = 3'b001;
  localparam logic [2:0] CSR_FUNCT3_RS  = 3'b010;
  localparam logic [2:0] CSR_FUNCT3_RC  = 3'b011;
  localparam logic [2:0] CSR_FUNCT3_RWI = 3'b101;
  localparam logic [2:0] CSR_FUNCT3_RSI = 3'b110;
  localparam logic [2:0] CSR_FUNCT3_RCI = 3'b111;

  // addr[11:10] value marking a read-only CSR
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

  // Legacy state encodings, kept bit-exact for the enum below
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_READ  = 2'b01;
  localparam logic [1:0] ST_WRITE = 2'b10;
  localparam logic [1:0] ST_RESP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_READ  = ST_READ,
    S_WRITE = ST_WRITE,
    S_RESP  = ST_RESP
  } state_t;

  function automatic logic is_read_only(input logic [1:0] addr_top);
    return addr_top == CSR_RO_FIELD;
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Execute-stage request/response handshake of the CSR access unit.
interface csr_access_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 12
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_csr_addr;
  logic [XLEN-1:0]   req_rs1_val;
  logic [4:0]        req_rs1_idx;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_illegal;

  // Execute stage side
  modport master (
    output req_valid, req_funct3, req_csr_addr, req_rs1_val, req_rs1_idx, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );

  // CSR access unit side
  modport slave (
    input  req_valid, req_funct3, req_csr_addr, req_rs1_val, req_rs1_idx, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );

endinterface

// File: rtl/csr_access_unit_csr_alu.sv
// Combinational CSR update: new value, write decision and legality check.
module csr_alu
  import csr_access_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  input  logic [4:0]      rs1_idx,
  input  logic            read_only,
  output logic [XLEN-1:0] new_val,
  output logic            do_write,
  output logic            illegal
);

  // Decode funct3 into update function, write decision and illegality
  always_comb begin
    new_val  = old_val;
    do_write = 1'b0;
    illegal  = 1'b0;
    unique case (funct3)
      CSR_FUNCT3_RW, CSR_FUNCT3_RWI: begin
        new_val  = operand;
        do_write = 1'b1;
      end
      CSR_FUNCT3_RS, CSR_FUNCT3_RSI: begin
        new_val  = old_val | operand;
        do_write = rs1_idx != 5'd0;
      end
      CSR_FUNCT3_RC, CSR_FUNCT3_RCI: begin
        new_val  = old_val & ~operand;
        do_write = rs1_idx != 5'd0;
      end
      default: illegal = 1'b1;
    endcase
    if (read_only && do_write)
      illegal = 1'b1;
  end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR register-file port: runs one Zicsr op through
// IDLE -> READ -> WRITE -> RESP and returns the old CSR value.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  csr_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] csr_r_addr,
  input  logic [XLEN-1:0]   csr_r_val,
  output logic [ADDR_W-1:0] csr_w_addr,
  output logic [XLEN-1:0]   csr_w_val,
  output logic              w_enable
);

  state_t          state;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] operand_q;
  logic [4:0]      rs1_idx_q;
  logic [XLEN-1:0] old_q;
  logic            illegal_q;

  logic [XLEN-1:0] alu_new;
  logic            alu_do_write;
  logic            alu_illegal;

  // csr_r_addr doubles as the latched request address.
  // The ALU sees csr_r_val directly during READ so the write data and strobe
  // can be registered at the READ->WRITE edge; that is the same value old_q
  // captures at that edge, so the WRITE-cycle result matches f(old_q, operand).
  csr_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .funct3    (funct3_q),
    .old_val   (csr_r_val),
    .operand   (operand_q),
    .rs1_idx   (rs1_idx_q),
    .read_only (is_read_only(csr_r_addr[ADDR_W-1 -: 2])),
    .new_val   (alu_new),
    .do_write  (alu_do_write),
    .illegal   (alu_illegal)
  );

  // FSM, request latches, old value capture, write strobe and response registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      funct3_q        <= '0;
      operand_q       <= '0;
      rs1_idx_q       <= '0;
      old_q           <= '0;
      illegal_q       <= 1'b0;
      csr_r_addr      <= '0;
      csr_w_addr      <= '0;
      csr_w_val       <= '0;
      w_enable        <= 1'b0;
      bus.req_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_illegal <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            funct3_q      <= bus.req_funct3;
            csr_r_addr    <= bus.req_csr_addr;
            rs1_idx_q     <= bus.req_rs1_idx;
            operand_q     <= bus.req_funct3[2] ? XLEN'(bus.req_rs1_idx) : bus.req_rs1_val;
            bus.req_ready <= 1'b0;
            state         <= S_READ;
          end
        end
        S_READ: begin
          old_q      <= csr_r_val;
          illegal_q  <= alu_illegal;
          csr_w_addr <= csr_r_addr;
          csr_w_val  <= alu_new;
          w_enable   <= alu_do_write && !alu_illegal;
          state      <= S_WRITE;
        end
        S_WRITE: begin
          w_enable        <= 1'b0;
          bus.rsp_valid   <= 1'b1;
          bus.rsp_rdata   <= illegal_q ? '0 : old_q;
          bus.rsp_illegal <= illegal_q;
          state           <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Testbench for csr_access_unit: behavioural CSR file stub plus a reference
// model of the Zicsr rules, directed cases followed by random ops.
module tb_csr_access_unit;

  logic        clock;
  logic        reset;
  logic [11:0] csr_r_addr;
  logic [31:0] csr_r_val;
  logic [11:0] csr_w_addr;
  logic [31:0] csr_w_val;
  logic        w_enable;

  int unsigned tests;
  int unsigned fails;

  // CSR file stub; pokes let the bench preload values
  logic [31:0] mem [0:4095];
  logic        poke_en;
  logic [11:0] poke_addr;
  logic [31:0] poke_val;
  logic [31:0] shadow [int];

  csr_access_unit_if #(.XLEN(32), .ADDR_W(12)) bus ();

  csr_access_unit #(
    .XLEN   (32),
    .ADDR_W (12)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .csr_r_addr (csr_r_addr),
    .csr_r_val  (csr_r_val),
    .csr_w_addr (csr_w_addr),
    .csr_w_val  (csr_w_val),
    .w_enable   (w_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign csr_r_val = mem[csr_r_addr];

  // Stub write port
  always @(posedge clock) begin
    if (poke_en) mem[poke_addr] <= poke_val;
    else if (w_enable) mem[csr_w_addr] <= csr_w_val;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] v);
    poke_en = 1'b1; poke_addr = a; poke_val = v;
    @(negedge clock);
    poke_en = 1'b0;
    shadow[int'(a)] = v;
  endtask

  // Reference: Zicsr semantics straight from funct3 meaning
  task automatic model(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                       input logic [4:0] idx, input logic [31:0] old,
                       output logic [31:0] rdata, output logic ill,
                       output logic wr, output logic [31:0] nv);
    logic [31:0] opnd;
    logic        legal;
    logic        wants;
    opnd  = (f3 >= 3'd4) ? {27'd0, idx} : rs1;
    legal = (f3 != 3'd0) && (f3 != 3'd4);
    case (f3)
      3'd1, 3'd5: begin nv = opnd;         wants = 1'b1;        end
      3'd2, 3'd6: begin nv = old | opnd;   wants = (idx != 0);  end
      3'd3, 3'd7: begin nv = old & ~opnd;  wants = (idx != 0);  end
      default:    begin nv = old;          wants = 1'b0;        end
    endcase
    ill   = !legal || ((a >= 12'hC00) && wants);
    wr    = !ill && wants;
    rdata = ill ? 32'd0 : old;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                        input logic [4:0] idx, input int unsigned hold);
    logic [31:0] e_rdata, e_new, w_val_seen;
    logic        e_ill, e_wr;
    int unsigned n, wcount;
    model(f3, a, rs1, idx, shadow[int'(a)], e_rdata, e_ill, e_wr, e_new);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_funct3 = f3; bus.req_csr_addr = a;
    bus.req_rs1_val = rs1; bus.req_rs1_idx = idx;
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_rs1_val = $urandom;
    check("r_addr", {20'd0, csr_r_addr}, {20'd0, a});
    n = 1; wcount = 0; w_val_seen = '0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin
      if (w_enable === 1'b1) begin
        wcount++;
        w_val_seen = csr_w_val;
        check("w_addr", {20'd0, csr_w_addr}, {20'd0, a});
        check("w_r_addr", {20'd0, csr_r_addr}, {20'd0, a});
      end
      @(negedge clock);
      n++;
    end
    check("latency", n, 32'd3);
    check("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("rsp_rdata", bus.rsp_rdata, e_rdata);
    check("rsp_illegal", {31'd0, bus.rsp_illegal}, {31'd0, e_ill});
    check("w_count", wcount, e_wr ? 32'd1 : 32'd0);
    if (e_wr) begin
      check("w_val", w_val_seen, e_new);
      shadow[int'(a)] = e_new;
    end
    for (int unsigned h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_funct3 = 3'($urandom);
      bus.req_csr_addr = 12'h300;
      @(negedge clock);
      check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("hold_rdata", bus.rsp_rdata, e_rdata);
      check("hold_ready", {31'd0, bus.req_ready}, 32'd0);
      check("hold_wen", {31'd0, w_enable}, 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    check("rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);
    check("ready_back", {31'd0, bus.req_ready}, 32'd1);
    check("csr_content", mem[a], shadow[int'(a)]);
  endtask

  logic [11:0] addr_pool [8];

  initial begin
    tests = 0; fails = 0;
    poke_en = 1'b0; poke_addr = '0; poke_val = '0;
    bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_csr_addr = '0;
    bus.req_rs1_val = '0; bus.req_rs1_idx = '0; bus.rsp_ready = 1'b0;
    reset = 1'b0;
    addr_pool[0] = 12'h300; addr_pool[1] = 12'h305; addr_pool[2] = 12'h340;
    addr_pool[3] = 12'h7C0; addr_pool[4] = 12'hF14; addr_pool[5] = 12'hC00;
    addr_pool[6] = 12'hB00; addr_pool[7] = 12'hBFF;
    repeat (3) @(negedge clock);

    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_illegal", {31'd0, bus.rsp_illegal}, 32'd0);
    check("rst_r_addr", {20'd0, csr_r_addr}, 32'd0);
    check("rst_w_addr", {20'd0, csr_w_addr}, 32'd0);
    check("rst_w_val", csr_w_val, 32'd0);
    check("rst_w_enable", {31'd0, w_enable}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);

    for (int unsigned i = 0; i < 8; i++) poke(addr_pool[i], $urandom);

    // CSRRW basic
    poke(12'h300, 32'hDEADBEEF);
    run_op(3'b001, 12'h300, 32'h12345678, 5'd5, 0);
    // CSRRS then CSRRC
    poke(12'h300, 32'h000000F0);
    run_op(3'b010, 12'h300, 32'h0000000F, 5'd1, 0);
    run_op(3'b011, 12'h300, 32'h000000F0, 5'd2, 0);
    check("rs_rc_result", mem[12'h300], 32'h0000000F);
    // Read-only CSR: CSRRSI x0 legal with no write, CSRRW illegal
    poke(12'hF14, 32'h00000007);
    run_op(3'b110, 12'hF14, 32'hFFFFFFFF, 5'd0, 0);
    run_op(3'b001, 12'hF14, 32'h0000FFFF, 5'd3, 0);
    // Reserved funct3 and full-range uimm
    run_op(3'b000, 12'h340, 32'h55555555, 5'd4, 0);
    run_op(3'b100, 12'h340, 32'h55555555, 5'd4, 0);
    run_op(3'b101, 12'h340, 32'hFFFFFFFF, 5'h1F, 0);
    check("rwi_result", mem[12'h340], 32'h0000001F);
    // Back-pressure on the response
    run_op(3'b001, 12'h305, 32'hA5A5A5A5, 5'd9, 5);

    // Reset during WRITE: strobe must drop immediately, CSR untouched
    poke(12'h7C0, 32'h11111111);
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b001; bus.req_csr_addr = 12'h7C0;
    bus.req_rs1_val = 32'hAAAA5555; bus.req_rs1_idx = 5'd1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    check("abort_wen_before", {31'd0, w_enable}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("abort_wen_async", {31'd0, w_enable}, 32'd0);
    check("abort_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clock);
    check("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("abort_ready_back", {31'd0, bus.req_ready}, 32'd1);
    check("abort_csr_kept", mem[12'h7C0], 32'h11111111);
    check("abort_no_rsp_after", {31'd0, bus.rsp_valid}, 32'd0);

    // Random ops against the reference model
    for (int unsigned i = 0; i < 60; i++) begin
      logic [2:0]  f3;
      logic [11:0] a;
      logic [4:0]  idx;
      f3  = 3'($urandom);
      a   = addr_pool[$urandom_range(0, 7)];
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_op(f3, a, $urandom, idx, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
